vga_capture: RTL and testbench

- Receive end of the team's VGA link: samples hSync/vSync and 5-bit RGB on the pixel clock and recovers raster position.
- Emits a frame-buffer write stream of packed 16-bit pixels plus lock/error status.
- Used as a loopback monitor for the VGA output path and as a video-input front end feeding on-chip pixel memory.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_sync_edge.sv | 55 +++++
 rtl/vga_capture.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_capture.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, capture state encoding and pixel packing
//
// Purpose : common definitions for the VGA capture path. The timing defaults
//           are the same 640x480@60 numbers the display side uses, so a
//           loopback of our own output locks with no overrides.
// Contents: VGA_* timing localparams, cap_state_t, pack_pixel().
package vga_pkg;

    // Default 640x480 raster timing, in pixels (H) and lines (V).
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_ADDR_W   = 19;

    // Capture sequencing: hunt for a vSync fall, wait for the line edge
    // that starts the frame, then capture.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        FRAME  = 2'd2
    } cap_state_t;

    // Frame-buffer word: 5:5:5 colour with a zero alpha bit in the LSB.
    function automatic logic [15:0] pack_pixel(input logic [4:0] r,
                                               input logic [4:0] g,
                                               input logic [4:0] b);
        return {r, g, b, 1'b0};
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - input registers and sync falling-edge detect for VGA capture
//
// Purpose : registers the sync lines twice (s1, s2) and flags a falling edge
//           when s2 is high and s1 is low. Because s2 follows s1, a sync that
//           stays low produces exactly one edge. RGB is registered once so
//           that it lines up with the s1 sync sample the edge refers to.
// Ports   : clk, rst         - pixel clock, asynchronous active-high reset
//           h_sync, v_sync   - raw active-low syncs from the pins
//           red/green/blue   - raw 5-bit colour samples
//           h_fall, v_fall   - one-cycle falling-edge flags (aligned to s1)
//           red_q/green_q/blue_q - s1 colour samples
module vga_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic [4:0] red,
    input  logic [4:0] green,
    input  logic [4:0] blue,
    output logic       h_fall,
    output logic       v_fall,
    output logic [4:0] red_q,
    output logic [4:0] green_q,
    output logic [4:0] blue_q
);

    logic h_s1, h_s2;
    logic v_s1, v_s2;

    // Syncs reset to their idle (high) level so reset release never looks
    // like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_s1    <= 1'b1;
            h_s2    <= 1'b1;
            v_s1    <= 1'b1;
            v_s2    <= 1'b1;
            red_q   <= 5'd0;
            green_q <= 5'd0;
            blue_q  <= 5'd0;
        end else begin
            h_s1    <= h_sync;
            h_s2    <= h_s1;
            v_s1    <= v_sync;
            v_s2    <= v_s1;
            red_q   <= red;
            green_q <= green;
            blue_q  <= blue;
        end
    end

    assign h_fall = h_s2 & ~h_s1;
    assign v_fall = v_s2 & ~v_s1;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive front end: raster recovery and frame-buffer write stream
//
// Purpose : recovers raster position from hSync/vSync, writes every active
//           pixel as a packed 16-bit word at address y*H_ACTIVE+x, and
//           reports lock and timing errors.
// Ports   : clk, reset        - pixel clock, asynchronous active-high reset
//           hSync, vSync      - active-low syncs
//           red, green, blue  - 5-bit colour samples
//           wr_en/wr_addr/wr_data - pixel write strobe, address, {r,g,b,0}
//           frame_done        - pulse the cycle after the last pixel write
//           locked            - set by an error-free frame, cleared on error
//           sync_error        - pulse on any timing violation
//           blank_violation   - pulse on non-black RGB outside the active
//                               window (only with VGA_BLANK_CHECK_EN defined,
//                               otherwise tied low)
// Macro   : VGA_BLANK_CHECK_EN enables the blanking-level checker.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int ADDR_W   = VGA_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hSync,
    input  logic              vSync,
    input  logic [4:0]        red,
    input  logic [4:0]        green,
    input  logic [4:0]        blue,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              locked,
    output logic              sync_error,
    output logic              blank_violation
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_MAX      = HW'(H_TOTAL);
    localparam logic [HW-1:0]     H_ACT_LO   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0]     H_ACT_HI   = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_MAX      = VW'(V_TOTAL);
    localparam logic [VW-1:0]     V_ACT_LO   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0]     V_ACT_HI   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic       h_fall, v_fall;
    logic [4:0] red_q, green_q, blue_q;

    vga_sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (reset),
        .h_sync  (hSync),
        .v_sync  (vSync),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .h_fall  (h_fall),
        .v_fall  (v_fall),
        .red_q   (red_q),
        .green_q (green_q),
        .blue_q  (blue_q)
    );

    // ------------------------------------------------------------------
    // Raster state
    // ------------------------------------------------------------------
    cap_state_t        state, state_next;
    logic [HW-1:0]     hcount, h_next;
    logic [VW-1:0]     vcount, v_next;
    logic [ADDR_W-1:0] addr_cnt;

    logic start_frame;
    logic good_end;
    logic err;
    logic h_act, v_act, in_window;
    logic wr_cond;

    // h_next/v_next are the raster position of the pixel currently in s1;
    // the registered hcount/vcount hold the position of the previous one.
    always_comb begin
        h_next = hcount;
        if (h_fall) begin
            h_next = '0;
        end else if (hcount != H_MAX) begin
            h_next = hcount + 1'b1;
        end
    end

    assign good_end = (state == FRAME) && v_fall && (vcount == V_LAST);

    // Timing checks. The first hSync fall after ARMED has no reference
    // line length, so it is exempt from the line-length check.
    always_comb begin
        err = 1'b0;
        if (state != SEARCH) begin
            if (h_fall && (hcount != H_LAST) && (state != ARMED)) begin
                err = 1'b1;
            end
            if (!h_fall && (hcount == H_LAST)) begin
                err = 1'b1;
            end
            if (state == FRAME) begin
                if (v_fall && (vcount != V_LAST)) begin
                    err = 1'b1;
                end
                if (h_fall && !v_fall && (vcount == V_LAST)) begin
                    err = 1'b1;
                end
            end
        end
    end

    // A vSync fall arms the frame; the hSync fall that starts line 0 may
    // arrive in the same cycle, in which case ARMED is skipped.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    if (h_fall) begin
                        state_next  = FRAME;
                        start_frame = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (h_fall) begin
                    state_next  = FRAME;
                    start_frame = 1'b1;
                end
            end
            FRAME: begin
                if (good_end) begin
                    if (h_fall) begin
                        start_frame = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
        if (err) begin
            state_next  = SEARCH;
            start_frame = 1'b0;
        end
    end

    always_comb begin
        v_next = vcount;
        if (start_frame) begin
            v_next = '0;
        end else if (h_fall && (vcount != V_MAX)) begin
            v_next = vcount + 1'b1;
        end
    end

    assign h_act     = (h_next >= H_ACT_LO) && (h_next <= H_ACT_HI);
    assign v_act     = (v_next >= V_ACT_LO) && (v_next <= V_ACT_HI);
    assign in_window = h_act && v_act;
    assign wr_cond   = (state == FRAME) && in_window && !err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            hcount     <= '0;
            vcount     <= '0;
            addr_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'd0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            state      <= state_next;
            hcount     <= h_next;
            vcount     <= v_next;
            sync_error <= err;
            wr_en      <= wr_cond;
            frame_done <= wr_en && (wr_addr == ADDR_LAST) && !err;

            if (wr_cond) begin
                wr_addr  <= addr_cnt;
                wr_data  <= pack_pixel(red_q, green_q, blue_q);
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (start_frame) begin
                addr_cnt <= '0;
            end

            if (err) begin
                locked <= 1'b0;
            end else if (good_end) begin
                locked <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blanking-level checker
    // ------------------------------------------------------------------
`ifdef VGA_BLANK_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_violation <= 1'b0;
        end else begin
            blank_violation <= (state == FRAME) && !in_window &&
                               ((red_q | green_q | blue_q) != 5'd0);
        end
    end
`else
    assign blank_violation = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed self-checking bench for vga_capture on a reduced raster
module tb_vga_capture;

    // Reduced raster: H_TOTAL = 15 (active h 5..12), V_TOTAL = 9 (active v 4..7)
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int AW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int NPIX = HA * VA;

    logic          clk = 1'b0;
    logic          reset;
    logic          hSync, vSync;
    logic [4:0]    red, green, blue;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done, locked, sync_error, blank_violation;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Monitor counters
    int            n_wr = 0, n_zero = 0, n_seq_bad = 0, n_data_bad = 0;
    int            n_fd = 0, n_serr = 0, n_blank = 0, serr_cyc = 0;
    logic [AW-1:0] m_last_addr = '0;
    logic [15:0]   m_last_data = '0;

    // Snapshots taken by the test tasks
    int s_wr, s_zero, s_seq, s_data, s_fd, s_serr, s_blank;
    int c0;
    int exp_blank;

    vga_capture #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .ADDR_W(AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hSync           (hSync),
        .vSync           (vSync),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .locked          (locked),
        .sync_error      (sync_error),
        .blank_violation (blank_violation)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected word for an address follows from the drive pattern
    // red = x+y, green = x, blue = y.
    always @(negedge clk) begin
        int a, x, y;
        logic [15:0] exp;
        if (wr_en) begin
            a = int'(wr_addr);
            x = a % HA;
            y = a / HA;
            exp = {5'(x + y), 5'(x), 5'(y), 1'b0};
            n_wr = n_wr + 1;
            if (a == 0) n_zero = n_zero + 1;
            else if (a != int'(m_last_addr) + 1) n_seq_bad = n_seq_bad + 1;
            if (wr_data !== exp) n_data_bad = n_data_bad + 1;
            m_last_addr = wr_addr;
            m_last_data = wr_data;
        end
        if (frame_done) n_fd = n_fd + 1;
        if (sync_error) begin
            n_serr = n_serr + 1;
            serr_cyc = cyc;
        end
        if (blank_violation) n_blank = n_blank + 1;
    end

    task automatic drive_raw(input logic hs, input logic vs, input logic [4:0] r,
                             input logic [4:0] g, input logic [4:0] b);
        hSync = hs;
        vSync = vs;
        red   = r;
        green = g;
        blue  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int h, input int v, input int bad_h);
        int x, y;
        logic [4:0] r, g, b;
        x = h - (HS + HB);
        y = v - (VS + VB);
        if (x >= 0 && x < HA && y >= 0 && y < VA) begin
            r = 5'(x + y);
            g = 5'(x);
            b = 5'(y);
        end else begin
            r = 5'd0;
            g = 5'd0;
            b = 5'd0;
        end
        if (h == bad_h) r = 5'h1F;
        drive_raw(h >= HS, v >= VS, r, g, b);
    endtask

    task automatic send_line(input int v, input int len, input int bad_h);
        for (int h = 0; h < len; h++) drive_pix(h, v, bad_h);
    endtask

    task automatic send_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) send_line(v, HT, -1);
    endtask

    task automatic snap();
        s_wr    = n_wr;
        s_zero  = n_zero;
        s_seq   = n_seq_bad;
        s_data  = n_data_bad;
        s_fd    = n_fd;
        s_serr  = n_serr;
        s_blank = n_blank;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) drive_raw(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if ({wr_en, frame_done, locked, sync_error, blank_violation, wr_addr, wr_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got en=%b fd=%b lk=%b se=%b bv=%b addr=%0d data=%h want all 0",
                     wr_en, frame_done, locked, sync_error, blank_violation, wr_addr, wr_data);
        end
        reset = 1'b0;
        snap();
        repeat (40) drive_raw(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if ((n_serr - s_serr) !== 0 || (n_wr - s_wr) !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle: got serr=%0d writes=%0d want 0 0", n_serr - s_serr, n_wr - s_wr);
        end
    endtask

    task automatic test_nominal();
        snap();
        send_lines(0, VB + VS + VA + VF - 1);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX) begin
            tests_failed++;
            $display("FAIL nom_f1_writes: got %0d want %0d", n_wr - s_wr, NPIX);
        end
        tests_run++;
        if ((n_zero - s_zero) !== 1 || (n_seq_bad - s_seq) !== 0) begin
            tests_failed++;
            $display("FAIL nom_f1_order: got zero=%0d seqbad=%0d want 1 0", n_zero - s_zero, n_seq_bad - s_seq);
        end
        tests_run++;
        if ((n_data_bad - s_data) !== 0) begin
            tests_failed++;
            $display("FAIL nom_f1_data: got %0d bad words want 0", n_data_bad - s_data);
        end
        tests_run++;
        if (m_last_addr !== 8'd31 || m_last_data !== 16'h51C6) begin
            tests_failed++;
            $display("FAIL nom_f1_last: got addr=%0d data=%h want 31 51c6", m_last_addr, m_last_data);
        end
        tests_run++;
        if ((n_fd - s_fd) !== 1 || (n_serr - s_serr) !== 0) begin
            tests_failed++;
            $display("FAIL nom_f1_status: got fd=%0d serr=%0d want 1 0", n_fd - s_fd, n_serr - s_serr);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL nom_f1_unlocked: got %b want 0", locked);
        end
        snap();
        send_line(0, HT, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL nom_f2_locked: got %b want 1", locked);
        end
        send_lines(1, 8);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_fd - s_fd) !== 1 || (n_serr - s_serr) !== 0 ||
            (n_data_bad - s_data) !== 0 || (n_zero - s_zero) !== 1) begin
            tests_failed++;
            $display("FAIL nom_f2: got wr=%0d fd=%0d serr=%0d bad=%0d zero=%0d want %0d 1 0 0 1",
                     n_wr - s_wr, n_fd - s_fd, n_serr - s_serr, n_data_bad - s_data, n_zero - s_zero, NPIX);
        end
    endtask

    task automatic test_short_line();
        snap();
        send_lines(0, 2);
        send_line(3, HT - 1, -1);
        c0 = cyc;
        send_line(4, HT, -1);
        tests_run++;
        if ((n_serr - s_serr) !== 1 || serr_cyc !== c0 + 2) begin
            tests_failed++;
            $display("FAIL short_err: got count=%0d at=%0d want 1 at %0d", n_serr - s_serr, serr_cyc, c0 + 2);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_unlock: got %b want 0", locked);
        end
        send_lines(5, 8);
        tests_run++;
        if ((n_wr - s_wr) !== 0) begin
            tests_failed++;
            $display("FAIL short_nowrite: got %0d writes want 0", n_wr - s_wr);
        end
        snap();
        send_lines(0, 8);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_fd - s_fd) !== 1 || (n_serr - s_serr) !== 0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_clean: got wr=%0d fd=%0d serr=%0d lk=%b want %0d 1 0 0",
                     n_wr - s_wr, n_fd - s_fd, n_serr - s_serr, locked, NPIX);
        end
        send_line(0, HT, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_relock: got %b want 1", locked);
        end
        send_lines(1, 8);
    endtask

    task automatic test_early_vsync();
        snap();
        send_line(0, HT, -1);
        send_lines(1, 4);
        tests_run++;
        if ((n_wr - s_wr) !== HA) begin
            tests_failed++;
            $display("FAIL early_partial: got %0d writes want %0d", n_wr - s_wr, HA);
        end
        snap();
        c0 = cyc;
        send_lines(0, 8);
        tests_run++;
        if ((n_serr - s_serr) !== 1 || serr_cyc !== c0 + 2 || locked !== 1'b0 || (n_wr - s_wr) !== 0) begin
            tests_failed++;
            $display("FAIL early_err: got serr=%0d at=%0d lk=%b wr=%0d want 1 at %0d 0 0",
                     n_serr - s_serr, serr_cyc, locked, n_wr - s_wr, c0 + 2);
        end
        snap();
        send_lines(0, 8);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_zero - s_zero) !== 1 || (n_seq_bad - s_seq) !== 0 || (n_serr - s_serr) !== 0) begin
            tests_failed++;
            $display("FAIL early_restart: got wr=%0d zero=%0d seqbad=%0d serr=%0d want %0d 1 0 0",
                     n_wr - s_wr, n_zero - s_zero, n_seq_bad - s_seq, n_serr - s_serr, NPIX);
        end
    endtask

    task automatic test_reset_mid();
        send_line(0, HT, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_prelock: got %b want 1", locked);
        end
        send_lines(1, 5);
        for (int h = 0; h <= 8; h++) drive_pix(h, 6, -1);
        tests_run++;
        if (wr_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_writing: got wr_en=%b want 1", wr_en);
        end
        #5;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({wr_en, frame_done, locked, sync_error, blank_violation, wr_addr, wr_data} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got en=%b fd=%b lk=%b se=%b bv=%b addr=%0d data=%h want all 0",
                     wr_en, frame_done, locked, sync_error, blank_violation, wr_addr, wr_data);
        end
        for (int h = 9; h <= 11; h++) drive_pix(h, 6, -1);
        reset = 1'b0;
        snap();
        for (int h = 12; h < HT; h++) drive_pix(h, 6, -1);
        send_lines(7, 8);
        tests_run++;
        if ((n_wr - s_wr) !== 0 || (n_serr - s_serr) !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: got wr=%0d serr=%0d want 0 0", n_wr - s_wr, n_serr - s_serr);
        end
        snap();
        send_lines(0, 8);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_zero - s_zero) !== 1 || (n_seq_bad - s_seq) !== 0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_restart: got wr=%0d zero=%0d seqbad=%0d lk=%b want %0d 1 0 0",
                     n_wr - s_wr, n_zero - s_zero, n_seq_bad - s_seq, locked, NPIX);
        end
    endtask

    task automatic test_blank();
`ifdef VGA_BLANK_CHECK_EN
        exp_blank = 1;
`else
        exp_blank = 0;
`endif
        snap();
        send_lines(0, 4);
        send_line(5, HT, 1);
        send_lines(6, 8);
        tests_run++;
        if ((n_blank - s_blank) !== exp_blank) begin
            tests_failed++;
            $display("FAIL blank_pulse: got %0d want %0d", n_blank - s_blank, exp_blank);
        end
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_data_bad - s_data) !== 0 || (n_seq_bad - s_seq) !== 0) begin
            tests_failed++;
            $display("FAIL blank_writes: got wr=%0d bad=%0d seqbad=%0d want %0d 0 0",
                     n_wr - s_wr, n_data_bad - s_data, n_seq_bad - s_seq, NPIX);
        end
        tests_run++;
        if (locked !== 1'b1 || (n_serr - s_serr) !== 0) begin
            tests_failed++;
            $display("FAIL blank_lock: got lk=%b serr=%0d want 1 0", locked, n_serr - s_serr);
        end
    endtask

    task automatic test_hsync_hold();
        send_lines(0, 1);
        snap();
        c0 = cyc;
        repeat (1000) drive_raw(1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        tests_run++;
        if ((n_serr - s_serr) !== 1 || serr_cyc !== c0 + 17) begin
            tests_failed++;
            $display("FAIL hold_err: got count=%0d at=%0d want 1 at %0d", n_serr - s_serr, serr_cyc, c0 + 17);
        end
        tests_run++;
        if (locked !== 1'b0 || (n_wr - s_wr) !== 0) begin
            tests_failed++;
            $display("FAIL hold_state: got lk=%b wr=%0d want 0 0", locked, n_wr - s_wr);
        end
        repeat (5) drive_raw(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        snap();
        send_lines(0, 8);
        tests_run++;
        if ((n_wr - s_wr) !== NPIX || (n_zero - s_zero) !== 1 || (n_fd - s_fd) !== 1 || (n_serr - s_serr) !== 0) begin
            tests_failed++;
            $display("FAIL hold_recover: got wr=%0d zero=%0d fd=%0d serr=%0d want %0d 1 1 0",
                     n_wr - s_wr, n_zero - s_zero, n_fd - s_fd, n_serr - s_serr, NPIX);
        end
    endtask

    initial begin
        reset = 1'b1;
        hSync = 1'b1;
        vSync = 1'b1;
        red   = 5'd0;
        green = 5'd0;
        blue  = 5'd0;
        test_reset();
        test_nominal();
        test_short_line();
        test_early_vsync();
        test_reset_mid();
        test_blank();
        test_hsync_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
